ace_snoop_ctrl: RTL



---
 rtl/ace_snoop_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ace_snoop_ctrl.sv
// ace_snoop_ctrl: snoop broadcast controller for the coherency unit.
// Takes one snoop job from the CCU, broadcasts it on AC to every port except
// the initiator, gathers the CR responses, then forwards the CD line from the
// lowest-index data-supplying port and drains CD from all other suppliers.
module ace_snoop_ctrl #(
  parameter int NoPorts   = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int CdBeats   = 4,
  localparam int IdxW     = ($clog2(NoPorts) > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // snoop job request from the CCU FSM
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic [3:0]                   req_snoop_i,
  input  logic [IdxW-1:0]              req_init_i,
  input  logic                         req_need_data_i,
  // per-port AC channel
  output logic [NoPorts-1:0]           ac_valid_o,
  input  logic [NoPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]         ac_addr_o,
  output logic [3:0]                   ac_snoop_o,
  // per-port CR channel
  input  logic [NoPorts-1:0]           cr_valid_i,
  output logic [NoPorts-1:0]           cr_ready_o,
  input  logic [5*NoPorts-1:0]         cr_resp_i,
  // per-port CD channel
  input  logic [NoPorts-1:0]           cd_valid_i,
  input  logic [DataWidth*NoPorts-1:0] cd_data_i,
  input  logic [NoPorts-1:0]           cd_last_i,
  output logic [NoPorts-1:0]           cd_ready_o,
  // forwarded cache line
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  output logic [DataWidth-1:0]         data_o,
  output logic                         data_last_o,
  // job completion
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [4:0]                   rsp_resp_o,
  output logic [IdxW-1:0]              rsp_src_o,
  output logic                         busy_o
);

  localparam int CntW = ($clog2(CdBeats + 1) > 1) ? $clog2(CdBeats + 1) : 1;

  typedef enum logic [1:0] {IDLE, SNOOP, DATA, RESP} state_t;

  state_t                 state;
  logic [NoPorts-1:0]     ac_pend;
  logic [NoPorts-1:0]     cr_pend;
  logic [NoPorts-1:0]     dt;
  logic [NoPorts-1:0]     done;
  logic [IdxW-1:0]        sel;
  logic                   need_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [3:0]             snoop_q;
  logic                   err_q;
  logic                   shared_q;
  logic                   unique_q;
  logic                   pd_q;
  logic [CntW-1:0]        cnt [NoPorts];

  logic [DataWidth-1:0]   cd_data_arr [NoPorts];
  logic [4:0]             cr_resp_arr [NoPorts];
  logic [NoPorts-1:0]     init_mask;
  logic [NoPorts-1:0]     ac_hs;
  logic [NoPorts-1:0]     cr_hs;
  logic [NoPorts-1:0]     cd_hs;
  logic [NoPorts-1:0]     cr_pend_nxt;
  logic [NoPorts-1:0]     dt_nxt;
  logic [NoPorts-1:0]     done_nxt;
  logic [IdxW-1:0]        sel_nxt;
  logic                   err_nxt;
  logic                   shared_nxt;
  logic                   unique_nxt;
  logic                   pd_nxt;
  logic [CntW-1:0]        cnt_nxt [NoPorts];

  for (genvar g = 0; g < NoPorts; g++) begin : g_unpack
    assign cd_data_arr[g] = cd_data_i[g*DataWidth +: DataWidth];
    assign cr_resp_arr[g] = cr_resp_i[g*5 +: 5];
  end

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);
  assign ac_addr_o   = addr_q;
  assign ac_snoop_o  = snoop_q;
  assign ac_valid_o  = (state == SNOOP) ? ac_pend : '0;
  assign cr_ready_o  = (state == SNOOP) ? (cr_pend & ~ac_pend) : '0;
  assign ac_hs       = ac_valid_o & ac_ready_i;
  assign cr_hs       = cr_valid_i & cr_ready_o;
  assign cd_hs       = cd_valid_i & cd_ready_o;

  assign data_o       = cd_data_arr[sel];
  assign data_last_o  = cd_last_i[sel];
  assign data_valid_o = (state == DATA) && need_q && !done[sel] && cd_valid_i[sel];

  assign rsp_valid_o = (state == RESP);
  assign rsp_resp_o  = (state == RESP) ? {unique_q, shared_q, pd_q, err_q, |dt} : '0;
  assign rsp_src_o   = (state == RESP) ? sel : '0;

  // One-hot of the requesting port, used to exclude it from the broadcast
  always_comb begin
    init_mask = '0;
    for (int i = 0; i < NoPorts; i++) begin
      init_mask[i] = (IdxW'(i) == req_init_i);
    end
  end

  // CD ready: the selected port follows the consumer when forwarding, every other supplier is drained
  always_comb begin
    cd_ready_o = '0;
    if (state == DATA) begin
      for (int i = 0; i < NoPorts; i++) begin
        if (dt[i] && !done[i]) begin
          if (need_q && (IdxW'(i) == sel)) begin
            cd_ready_o[i] = data_ready_i;
          end else begin
            cd_ready_o[i] = 1'b1;
          end
        end
      end
    end
  end

  // Next-state bookkeeping for CR collection, CD beat counting and supplier selection
  always_comb begin
    cr_pend_nxt = cr_pend & ~cr_hs;
    dt_nxt      = dt;
    done_nxt    = done;
    err_nxt     = err_q;
    shared_nxt  = shared_q;
    unique_nxt  = unique_q;
    pd_nxt      = pd_q;
    cnt_nxt     = cnt;
    sel_nxt     = '0;
    for (int i = 0; i < NoPorts; i++) begin
      if (cr_hs[i]) begin
        err_nxt    = err_nxt    | cr_resp_arr[i][1];
        shared_nxt = shared_nxt | cr_resp_arr[i][3];
        unique_nxt = unique_nxt | cr_resp_arr[i][4];
        pd_nxt     = pd_nxt     | (cr_resp_arr[i][0] & cr_resp_arr[i][2]);
        dt_nxt[i]  = cr_resp_arr[i][0];
      end
      if (cd_hs[i]) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
        if (cd_last_i[i]) begin
          done_nxt[i] = 1'b1;
          if (cnt_nxt[i] != CntW'(CdBeats)) begin
            err_nxt = 1'b1;
          end
        end else if (cnt_nxt[i] == CntW'(CdBeats)) begin
          done_nxt[i] = 1'b1;
          err_nxt     = 1'b1;
        end
      end
    end
    for (int i = NoPorts - 1; i >= 0; i--) begin
      if (dt_nxt[i]) begin
        sel_nxt = IdxW'(i);
      end
    end
  end

  // Job FSM: accept, broadcast/collect, move data, report
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ac_pend  <= '0;
      cr_pend  <= '0;
      dt       <= '0;
      done     <= '0;
      sel      <= '0;
      need_q   <= 1'b0;
      addr_q   <= '0;
      snoop_q  <= '0;
      err_q    <= 1'b0;
      shared_q <= 1'b0;
      unique_q <= 1'b0;
      pd_q     <= 1'b0;
      for (int i = 0; i < NoPorts; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            snoop_q  <= req_snoop_i;
            need_q   <= req_need_data_i;
            ac_pend  <= ~init_mask;
            cr_pend  <= ~init_mask;
            dt       <= '0;
            done     <= '0;
            sel      <= '0;
            err_q    <= 1'b0;
            shared_q <= 1'b0;
            unique_q <= 1'b0;
            pd_q     <= 1'b0;
            for (int i = 0; i < NoPorts; i++) begin
              cnt[i] <= '0;
            end
            state <= SNOOP;
          end
        end
        SNOOP: begin
          ac_pend  <= ac_pend & ~ac_hs;
          cr_pend  <= cr_pend_nxt;
          dt       <= dt_nxt;
          err_q    <= err_nxt;
          shared_q <= shared_nxt;
          unique_q <= unique_nxt;
          pd_q     <= pd_nxt;
          if (cr_pend_nxt == '0) begin
            sel   <= sel_nxt;
            state <= (dt_nxt == '0) ? RESP : DATA;
          end
        end
        DATA: begin
          done  <= done_nxt;
          cnt   <= cnt_nxt;
          err_q <= err_nxt;
          if ((done_nxt & dt) == dt) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
